div_1: RTL and testbench

DIV_1 -- requirements
Module: div_1

---
 rtl/div_1_if.sv | 24 ++
 rtl/div_1.sv | 92 +++++++++
 tb/tb_div_1.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/div_1_if.sv
// Division request/result bundle: the requester drives start/Q/B,
// the divider drives the registered results and status flags.
interface div_1_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, Q, B,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, Q, B,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_1.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// A start accepted on edge k completes on edge k+WIDTH with a one-cycle done pulse.
module div_1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    div_1_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StCalc} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs;      // latched divisor
    logic [WIDTH-1:0] prem;     // partial remainder
    logic [CW-1:0]    cnt;      // iterations left
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quo;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted = {prem, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        // Divisor is below 2^WIDTH, so a set top bit always fits; otherwise the
        // difference top bit is the borrow.
        fits     = shifted[WIDTH] | ~diff[WIDTH];
        next_rem = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        next_quo = {dvd[WIDTH-2:0], fits};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            dvd    <= '0;
            dvs    <= '0;
            prem   <= '0;
            cnt    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        dvd    <= bus.Q;
                        dvs    <= bus.B;
                        prem   <= '0;
                        cnt    <= CW'(WIDTH);
                        busy_q <= 1'b1;
                        state  <= StCalc;
                    end
                end
                StCalc: begin
                    dvd  <= next_quo;
                    prem <= next_rem;
                    cnt  <= cnt - 1'b1;
                    // With B == 0 every trial fits, giving all-ones and remainder = Q.
                    if (cnt == CW'(1)) begin
                        quo_q  <= next_quo;
                        rem_q  <= next_rem;
                        dbz_q  <= (dvs == '0);
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_1.sv
// Scoreboard bench for div_1 (WIDTH=8): expected results queued at start, checked at done.
module tb_div_1;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_1_if #(.WIDTH(WIDTH)) bus ();

    div_1 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] quo;
        logic [7:0] rem;
        logic       dbz;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   cycle = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;
    int   exp_done = 0;
    int   prev_done_cyc = 0;
    int   done_gap = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] q, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.quo = 8'hFF;
            e.rem = q;
            e.dbz = 1'b1;
        end else begin
            e.quo = q / b;
            e.rem = q % b;
            e.dbz = 1'b0;
        end
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            exp_t e;
            n_done++;
            done_gap = cycle - prev_done_cyc;
            prev_done_cyc = cycle;
            check("busy_with_done", 32'(bus.busy), 32'd0);
            check("done_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("quotient", 32'(bus.quotient), 32'(e.quo));
                check("remainder", 32'(bus.remainder), 32'(e.rem));
                check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                check("latency", 32'(cycle), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; start is sampled on the following posedge.
    task automatic go(input logic [7:0] q, input logic [7:0] b, input bit accept);
        exp_t e;
        bus.Q = q;
        bus.B = b;
        bus.start = 1'b1;
        if (accept) begin
            e = model(q, b);
            e.cyc = cycle + 9;
            sb.push_back(e);
            last_exp = e;
            exp_done++;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
        check({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.Q = '0;
        bus.B = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic operations including divide-by-zero.
        go(8'd57, 8'd3, 1'b1);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        wait_idle();
        go(8'd255, 8'd16, 1'b1);
        wait_idle();
        go(8'd3, 8'd7, 1'b1);
        wait_idle();
        go(8'd5, 8'd0, 1'b1);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            go(8'($urandom_range(0, 255)), (i == 3) ? 8'd0 : 8'($urandom_range(1, 255)), 1'b1);
            wait_idle();
        end

        // Start and operand changes while busy are ignored; results hold during CALC.
        begin
            exp_t prev;
            prev = last_exp;
            go(8'd100, 8'd7, 1'b1);
            repeat (2) @(negedge clk);
            go(8'd9, 8'd3, 1'b0);
            check("hold_quotient", 32'(bus.quotient), 32'(prev.quo));
            check("hold_remainder", 32'(bus.remainder), 32'(prev.rem));
            wait_idle();
            repeat (12) @(negedge clk);
            check("single_done", 32'(n_done), 32'(exp_done));
        end

        // Reset four cycles into an operation aborts it silently.
        go(8'd77, 8'd5, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        exp_done--;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", 32'(n_done), 32'(exp_done));
        go(8'd200, 8'd10, 1'b1);
        wait_idle();

        // Back-to-back: second start issued in the done cycle of the first.
        go(8'd57, 8'd3, 1'b1);
        begin
            int n = 0;
            while (bus.done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_first_done_seen", 32'(bus.done), 32'd1);
        end
        go(8'd250, 8'd9, 1'b1);
        wait_idle();
        check("b2b_gap", 32'(done_gap), 32'd9);

        repeat (4) @(negedge clk);
        check("total_done", 32'(n_done), 32'(exp_done));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
